// File: rtl/batrider_gfx_arb.sv
// ============================================================================
// Module   : batrider_gfx_arb
// Purpose  : Round-robin arbiter merging the four GP9001 graphics-ROM fetch
//            paths (OBJ, SCR0, SCR1, SCR2) onto a single SDRAM ROM read slot.
//            Each requester owns a data register tagged with the address it
//            was filled from, so repeated reads of the same address are
//            answered with no ROM access.
// Ports    : CLK96    - system clock, all state on rising edge
//            RESET96  - synchronous active-high reset
//            REQ_CS   - per-requester read request (bit0 OBJ .. bit3 SCR2)
//            REQ_ADDR - per-requester word address, slice i = [i*AW +: AW]
//            REQ_DOUT - per-requester returned data, slice i = [i*DW +: DW]
//            REQ_OK   - per-requester data valid for current REQ_ADDR
//            ROM_CS   - registered ROM read strobe
//            ROM_ADDR - registered ROM address
//            ROM_DATA - ROM read data
//            ROM_OK   - ROM data valid for ROM_ADDR
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module batrider_gfx_arb #(
    parameter int AW = 22,
    parameter int DW = 32
) (
    input  logic            CLK96,
    input  logic            RESET96,
    input  logic [3:0]      REQ_CS,
    input  logic [4*AW-1:0] REQ_ADDR,
    output logic [4*DW-1:0] REQ_DOUT,
    output logic [3:0]      REQ_OK,
    output logic            ROM_CS,
    output logic [AW-1:0]   ROM_ADDR,
    input  logic [DW-1:0]   ROM_DATA,
    input  logic            ROM_OK
);

    localparam int         c_NUM_REQ = 4;
    localparam logic [0:0] c_ST_IDLE = 1'b0;
    localparam logic [0:0] c_ST_WAIT = 1'b1;

    logic [0:0]    r_state;
    logic [0:0]    w_state_nxt;

    logic [DW-1:0] r_data [c_NUM_REQ];
    logic [AW-1:0] r_tag  [c_NUM_REQ];
    logic [3:0]    r_valid;
    logic [1:0]    r_ptr;
    logic [1:0]    r_gnt;
    logic          r_first;
    logic          r_rom_cs;
    logic [AW-1:0] r_rom_addr;

    logic [3:0]    w_hit;
    logic [3:0]    w_pending;
    logic          w_any_pending;
    logic [1:0]    w_pick;
    logic [AW-1:0] w_pick_addr;
    logic          w_launch;
    logic          w_capture;

    // ------------------------------------------------------------------
    // Per-requester tag compare and response outputs
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < c_NUM_REQ; gi++) begin : g_req
            assign w_hit[gi]     = r_valid[gi] && (r_tag[gi] == REQ_ADDR[gi*AW +: AW]);
            assign w_pending[gi] = REQ_CS[gi] & ~w_hit[gi];
            assign REQ_OK[gi]    = REQ_CS[gi] & w_hit[gi];
            assign REQ_DOUT[gi*DW +: DW] = r_data[gi];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Round-robin pick: first pending index at or after r_ptr, modulo 4.
    // Scanning from the far end lets the nearest pending index win last.
    // ------------------------------------------------------------------
    always_comb begin
        w_pick        = r_ptr;
        w_any_pending = 1'b0;
        for (int k = c_NUM_REQ - 1; k >= 0; k--) begin
            if (w_pending[r_ptr + 2'(k)]) begin
                w_pick        = r_ptr + 2'(k);
                w_any_pending = 1'b1;
            end
        end
    end

    always_comb begin
        w_pick_addr = '0;
        case (w_pick)
            2'd0:    w_pick_addr = REQ_ADDR[0*AW +: AW];
            2'd1:    w_pick_addr = REQ_ADDR[1*AW +: AW];
            2'd2:    w_pick_addr = REQ_ADDR[2*AW +: AW];
            default: w_pick_addr = REQ_ADDR[3*AW +: AW];
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge CLK96) begin
        if (RESET96) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: if (w_any_pending)       w_state_nxt = c_ST_WAIT;
            c_ST_WAIT: if (ROM_OK && !r_first)  w_state_nxt = c_ST_IDLE;
            default:                            w_state_nxt = c_ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: control strobes. ROM_OK is ignored in the first WAIT cycle so a
    // level left high from the previous access cannot complete this one.
    // ------------------------------------------------------------------
    always_comb begin
        w_launch  = 1'b0;
        w_capture = 1'b0;
        case (r_state)
            c_ST_IDLE: w_launch  = w_any_pending;
            c_ST_WAIT: w_capture = ROM_OK & ~r_first;
            default: begin
                w_launch  = 1'b0;
                w_capture = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath. A started access always completes and is tagged with the
    // address that was sent to the ROM, whatever the requester does now.
    // ------------------------------------------------------------------
    always_ff @(posedge CLK96) begin
        if (RESET96) begin
            r_rom_cs   <= 1'b0;
            r_rom_addr <= '0;
            r_ptr      <= 2'd0;
            r_gnt      <= 2'd0;
            r_first    <= 1'b0;
            r_valid    <= 4'b0000;
            for (int i = 0; i < c_NUM_REQ; i++) begin
                r_data[i] <= '0;
                r_tag[i]  <= '0;
            end
        end else begin
            r_first <= 1'b0;
            if (w_launch) begin
                r_gnt      <= w_pick;
                r_rom_addr <= w_pick_addr;
                r_rom_cs   <= 1'b1;
                r_first    <= 1'b1;
            end
            if (w_capture) begin
                r_data[r_gnt]  <= ROM_DATA;
                r_tag[r_gnt]   <= r_rom_addr;
                r_valid[r_gnt] <= 1'b1;
                r_ptr          <= r_gnt + 2'd1;
                r_rom_cs       <= 1'b0;
            end
        end
    end

    assign ROM_CS   = r_rom_cs;
    assign ROM_ADDR = r_rom_addr;

endmodule

`default_nettype wire

// File: tb/tb_batrider_gfx_arb.sv
// ============================================================================
// Module   : tb_batrider_gfx_arb
// Purpose  : Self-checking bench for batrider_gfx_arb. A behavioural model
//            (per-requester cache entries plus a rotating pointer) predicts
//            grants, REQ_OK and REQ_DOUT; the bench also plays the ROM.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_batrider_gfx_arb;

    localparam int AW = 22;
    localparam int DW = 32;

    logic            CLK96 = 1'b0;
    logic            RESET96 = 1'b1;
    logic [3:0]      REQ_CS = '0;
    logic [4*AW-1:0] REQ_ADDR = '0;
    logic [4*DW-1:0] REQ_DOUT;
    logic [3:0]      REQ_OK;
    logic            ROM_CS;
    logic [AW-1:0]   ROM_ADDR;
    logic [DW-1:0]   ROM_DATA = '0;
    logic            ROM_OK = 1'b0;

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit            m_valid [4];
    logic [AW-1:0] m_tag   [4];
    logic [DW-1:0] m_data  [4];
    int            m_ptr;
    logic [AW-1:0] obs_addr [$];

    batrider_gfx_arb #(.AW(AW), .DW(DW)) dut (
        .CLK96    (CLK96),
        .RESET96  (RESET96),
        .REQ_CS   (REQ_CS),
        .REQ_ADDR (REQ_ADDR),
        .REQ_DOUT (REQ_DOUT),
        .REQ_OK   (REQ_OK),
        .ROM_CS   (ROM_CS),
        .ROM_ADDR (ROM_ADDR),
        .ROM_DATA (ROM_DATA),
        .ROM_OK   (ROM_OK)
    );

    always #5 CLK96 = ~CLK96;

    // ---------------- model helpers ----------------
    function automatic logic [DW-1:0] rom_fn(input logic [AW-1:0] a);
        if (a == 22'h00123) return 32'hDEADBEEF;
        return {a[9:0], a} ^ 32'h5A3C_96E1;
    endfunction

    function automatic logic [AW-1:0] addr_of(input int i);
        return REQ_ADDR[i*AW +: AW];
    endfunction

    function automatic bit model_hit(input int i);
        return m_valid[i] && (m_tag[i] == addr_of(i));
    endfunction

    function automatic logic [3:0] model_ok();
        logic [3:0] v;
        for (int i = 0; i < 4; i++) v[i] = REQ_CS[i] && model_hit(i);
        return v;
    endfunction

    function automatic logic [4*DW-1:0] model_dout();
        logic [4*DW-1:0] v;
        for (int i = 0; i < 4; i++) v[i*DW +: DW] = m_data[i];
        return v;
    endfunction

    function automatic int model_pick();
        for (int k = 0; k < 4; k++) begin
            int idx;
            idx = (m_ptr + k) % 4;
            if (REQ_CS[idx] && !model_hit(idx)) return idx;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_valid[i] = 1'b0;
            m_tag[i]   = '0;
            m_data[i]  = '0;
        end
        m_ptr = 0;
    endtask

    task automatic set_addr(input int i, input logic [AW-1:0] a);
        REQ_ADDR[i*AW +: AW] = a;
    endtask

    task automatic apply_reset();
        RESET96 = 1'b1;
        REQ_CS  = '0;
        ROM_OK  = 1'b0;
        repeat (3) @(negedge CLK96);
        RESET96 = 1'b0;
        model_reset();
    endtask

    // Serve up to max_acc accesses with inputs held static; the model
    // decides which requester must be granted next.
    task automatic run_arb(input int max_acc, input int fixed_lat);
        for (int n = 0; n < max_acc; n++) begin
            int g;
            int t;
            int lat;
            logic [AW-1:0] a;
            g = model_pick();
            if (g < 0) break;
            a = addr_of(g);
            t = 0;
            do begin
                @(negedge CLK96);
                t++;
            end while (ROM_CS !== 1'b1 && t < 20);
            checks++;
            if (ROM_CS !== 1'b1) begin
                errors++;
                $display("FAIL grant_timeout req=%0d rom_cs=%b expected 1", g, ROM_CS);
                return;
            end
            checks++;
            if (ROM_ADDR !== a) begin
                errors++;
                $display("FAIL grant_addr req=%0d rom_addr=%h expected %h", g, ROM_ADDR, a);
            end
            obs_addr.push_back(ROM_ADDR);
            lat = (fixed_lat > 0) ? fixed_lat : int'($urandom_range(1, 4));
            repeat (lat) @(negedge CLK96);
            ROM_DATA = rom_fn(a);
            ROM_OK   = 1'b1;
            @(negedge CLK96);
            ROM_OK   = 1'b0;
            ROM_DATA = $urandom;
            m_valid[g] = 1'b1;
            m_tag[g]   = a;
            m_data[g]  = rom_fn(a);
            m_ptr      = (g + 1) % 4;
            checks++;
            if (ROM_CS !== 1'b0) begin
                errors++;
                $display("FAIL rom_cs_gap rom_cs=%b expected 0", ROM_CS);
            end
            checks++;
            if (REQ_OK !== model_ok()) begin
                errors++;
                $display("FAIL req_ok_after_fill req_ok=%b expected %b", REQ_OK, model_ok());
            end
            checks++;
            if (REQ_DOUT !== model_dout()) begin
                errors++;
                $display("FAIL req_dout_after_fill dout=%h expected %h", REQ_DOUT, model_dout());
            end
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        RESET96 = 1'b1;
        REQ_CS  = 4'b1111;
        repeat (2) @(negedge CLK96);
        checks++;
        if (ROM_CS !== 1'b0 || ROM_ADDR !== '0) begin
            errors++;
            $display("FAIL reset_rom rom_cs=%b rom_addr=%h expected 0/0", ROM_CS, ROM_ADDR);
        end
        checks++;
        if (REQ_OK !== 4'b0000 || REQ_DOUT !== '0) begin
            errors++;
            $display("FAIL reset_req req_ok=%b dout=%h expected 0/0", REQ_OK, REQ_DOUT);
        end
        REQ_CS  = '0;
        RESET96 = 1'b0;
        model_reset();
        @(negedge CLK96);
        checks++;
        if (ROM_CS !== 1'b0 || REQ_OK !== 4'b0000) begin
            errors++;
            $display("FAIL reset_release rom_cs=%b req_ok=%b expected 0/0000", ROM_CS, REQ_OK);
        end
    endtask

    task automatic test_single_read();
        set_addr(0, 22'h00123);
        REQ_CS = 4'b0001;
        #1;
        checks++;
        if (REQ_OK !== 4'b0000) begin
            errors++;
            $display("FAIL single_pre_ok req_ok=%b expected 0000", REQ_OK);
        end
        obs_addr.delete();
        run_arb(1, 3);
        checks++;
        if (obs_addr.size() != 1 || obs_addr[0] !== 22'h00123) begin
            errors++;
            $display("FAIL single_rom_addr count=%0d expected 1 at 000123", obs_addr.size());
        end
        checks++;
        if (REQ_OK[0] !== 1'b1 || REQ_DOUT[31:0] !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL single_data ok=%b dout=%h expected 1/deadbeef", REQ_OK[0], REQ_DOUT[31:0]);
        end
        @(negedge CLK96);
        checks++;
        if (ROM_CS !== 1'b0) begin
            errors++;
            $display("FAIL single_idle rom_cs=%b expected 0", ROM_CS);
        end
    endtask

    task automatic test_cache_hit();
        bit saw_cs;
        @(negedge CLK96);
        REQ_CS = 4'b0000;
        #1;
        checks++;
        if (REQ_OK !== 4'b0000) begin
            errors++;
            $display("FAIL hit_cs_low req_ok=%b expected 0000", REQ_OK);
        end
        @(negedge CLK96);
        REQ_CS = 4'b0001;
        #1;
        checks++;
        if (REQ_OK !== 4'b0001 || REQ_DOUT[31:0] !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL hit_same_cycle req_ok=%b dout=%h expected 0001/deadbeef", REQ_OK, REQ_DOUT[31:0]);
        end
        saw_cs = 1'b0;
        repeat (4) begin
            @(negedge CLK96);
            if (ROM_CS !== 1'b0) saw_cs = 1'b1;
        end
        checks++;
        if (saw_cs) begin
            errors++;
            $display("FAIL hit_no_rom rom_cs pulsed=1 expected 0");
        end
        set_addr(0, 22'h00124);
        #1;
        checks++;
        if (REQ_OK[0] !== 1'b0) begin
            errors++;
            $display("FAIL miss_ok req_ok0=%b expected 0", REQ_OK[0]);
        end
        obs_addr.delete();
        run_arb(1, 0);
        checks++;
        if (obs_addr.size() != 1 || obs_addr[0] !== 22'h00124) begin
            errors++;
            $display("FAIL miss_rom_addr count=%0d expected 1 at 000124", obs_addr.size());
        end
    endtask

    task automatic test_contention();
        logic [AW-1:0] exp_seq [6];
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            exp_seq[i] = 22'h0A000 + AW'(i);
            set_addr(i, exp_seq[i]);
        end
        REQ_CS = 4'b1111;
        obs_addr.delete();
        run_arb(4, 0);
        checks++;
        if (obs_addr.size() != 4) begin
            errors++;
            $display("FAIL rr_count count=%0d expected 4", obs_addr.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (obs_addr[i] !== exp_seq[i]) begin
                    errors++;
                    $display("FAIL rr_order slot=%0d rom_addr=%h expected %h", i, obs_addr[i], exp_seq[i]);
                end
            end
        end
        // one more OBJ access moves the pointer to 1
        set_addr(0, 22'h0B000);
        run_arb(1, 0);
        set_addr(0, 22'h0C000);
        set_addr(3, 22'h0C003);
        exp_seq[4] = 22'h0C003;
        exp_seq[5] = 22'h0C000;
        obs_addr.delete();
        run_arb(2, 0);
        checks++;
        if (obs_addr.size() != 2 || obs_addr[0] !== exp_seq[4] || obs_addr[1] !== exp_seq[5]) begin
            errors++;
            $display("FAIL rr_wrap count=%0d expected order %h then %h", obs_addr.size(), exp_seq[4], exp_seq[5]);
        end
    endtask

    task automatic test_abandon();
        int t;
        bit saw_cs;
        REQ_CS = 4'b0000;
        set_addr(2, 22'h0D222);
        REQ_CS = 4'b0100;
        t = 0;
        do begin @(negedge CLK96); t++; end while (ROM_CS !== 1'b1 && t < 20);
        checks++;
        if (ROM_CS !== 1'b1 || ROM_ADDR !== 22'h0D222) begin
            errors++;
            $display("FAIL abandon_grant rom_cs=%b rom_addr=%h expected 1/0d222", ROM_CS, ROM_ADDR);
        end
        REQ_CS[2] = 1'b0;
        repeat (2) @(negedge CLK96);
        ROM_DATA = rom_fn(22'h0D222);
        ROM_OK   = 1'b1;
        @(negedge CLK96);
        ROM_OK   = 1'b0;
        m_valid[2] = 1'b1; m_tag[2] = 22'h0D222; m_data[2] = rom_fn(22'h0D222); m_ptr = 3;
        checks++;
        if (ROM_CS !== 1'b0 || REQ_OK !== 4'b0000) begin
            errors++;
            $display("FAIL abandon_done rom_cs=%b req_ok=%b expected 0/0000", ROM_CS, REQ_OK);
        end
        saw_cs = 1'b0;
        repeat (3) begin
            @(negedge CLK96);
            if (ROM_CS !== 1'b0) saw_cs = 1'b1;
        end
        REQ_CS = 4'b0100;
        #1;
        checks++;
        if (saw_cs || REQ_OK !== 4'b0100 || REQ_DOUT[2*DW +: DW] !== rom_fn(22'h0D222)) begin
            errors++;
            $display("FAIL abandon_rehit req_ok=%b dout2=%h extra_cs=%b expected 0100/%h/0",
                     REQ_OK, REQ_DOUT[2*DW +: DW], saw_cs, rom_fn(22'h0D222));
        end
        // address change while granted: old address stored, new one re-pends
        set_addr(2, 22'h0D444);
        t = 0;
        do begin @(negedge CLK96); t++; end while (ROM_CS !== 1'b1 && t < 20);
        set_addr(2, 22'h0D555);
        @(negedge CLK96);
        ROM_DATA = rom_fn(22'h0D444);
        ROM_OK   = 1'b1;
        @(negedge CLK96);
        ROM_OK   = 1'b0;
        m_tag[2] = 22'h0D444; m_data[2] = rom_fn(22'h0D444); m_ptr = 3;
        checks++;
        if (REQ_OK !== 4'b0000 || REQ_DOUT[2*DW +: DW] !== rom_fn(22'h0D444)) begin
            errors++;
            $display("FAIL addr_change req_ok=%b dout2=%h expected 0000/%h", REQ_OK, REQ_DOUT[2*DW +: DW], rom_fn(22'h0D444));
        end
        obs_addr.delete();
        run_arb(1, 0);
        checks++;
        if (obs_addr.size() != 1 || obs_addr[0] !== 22'h0D555) begin
            errors++;
            $display("FAIL addr_change_repend count=%0d expected 1 at 0d555", obs_addr.size());
        end
    endtask

    task automatic test_stale_ok();
        REQ_CS   = 4'b0000;
        set_addr(1, 22'h0E111);
        ROM_OK   = 1'b1;
        ROM_DATA = 32'h0BAD0BAD;
        REQ_CS   = 4'b0010;
        @(negedge CLK96);
        checks++;
        if (ROM_CS !== 1'b1 || ROM_ADDR !== 22'h0E111) begin
            errors++;
            $display("FAIL stale_grant rom_cs=%b rom_addr=%h expected 1/0e111", ROM_CS, ROM_ADDR);
        end
        @(negedge CLK96);
        checks++;
        if (ROM_CS !== 1'b1 || REQ_OK !== 4'b0000) begin
            errors++;
            $display("FAIL stale_ignored rom_cs=%b req_ok=%b expected 1/0000", ROM_CS, REQ_OK);
        end
        ROM_DATA = rom_fn(22'h0E111);
        @(negedge CLK96);
        ROM_OK = 1'b0;
        m_valid[1] = 1'b1; m_tag[1] = 22'h0E111; m_data[1] = rom_fn(22'h0E111); m_ptr = 2;
        checks++;
        if (ROM_CS !== 1'b0 || REQ_OK !== 4'b0010 || REQ_DOUT[1*DW +: DW] !== rom_fn(22'h0E111)) begin
            errors++;
            $display("FAIL stale_capture rom_cs=%b req_ok=%b dout1=%h expected 0/0010/%h",
                     ROM_CS, REQ_OK, REQ_DOUT[1*DW +: DW], rom_fn(22'h0E111));
        end
    endtask

    task automatic test_reset_mid_wait();
        REQ_CS = 4'b0000;
        set_addr(3, 22'h0F333);
        REQ_CS = 4'b1000;
        @(negedge CLK96);
        checks++;
        if (ROM_CS !== 1'b1) begin
            errors++;
            $display("FAIL rmw_grant rom_cs=%b expected 1", ROM_CS);
        end
        RESET96 = 1'b1;
        REQ_CS  = 4'b0111;
        @(negedge CLK96);
        checks++;
        if (ROM_CS !== 1'b0 || REQ_OK !== 4'b0000 || REQ_DOUT !== '0) begin
            errors++;
            $display("FAIL rmw_reset rom_cs=%b req_ok=%b dout=%h expected 0/0000/0", ROM_CS, REQ_OK, REQ_DOUT);
        end
        RESET96  = 1'b0;
        REQ_CS   = 4'b0000;
        ROM_OK   = 1'b1;
        ROM_DATA = 32'hFEEDFACE;
        model_reset();
        @(negedge CLK96);
        ROM_OK = 1'b0;
        REQ_CS = 4'b0111;
        #1;
        checks++;
        if (ROM_CS !== 1'b0 || REQ_OK !== 4'b0000 || REQ_DOUT !== '0) begin
            errors++;
            $display("FAIL rmw_late_ok rom_cs=%b req_ok=%b dout=%h expected 0/0000/0", ROM_CS, REQ_OK, REQ_DOUT);
        end
        for (int i = 0; i < 4; i++) set_addr(i, 22'h11000 + AW'(i));
        REQ_CS = 4'b1111;
        obs_addr.delete();
        run_arb(4, 0);
        checks++;
        if (obs_addr.size() == 0 || obs_addr[0] !== 22'h11000) begin
            errors++;
            $display("FAIL rmw_restart count=%0d expected first grant at 11000", obs_addr.size());
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 200; r++) begin
            REQ_CS = 4'($urandom_range(0, 15));
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(0, 1) == 1)
                    set_addr(i, 22'h20000 + AW'($urandom_range(0, 3)));
            end
            #1;
            checks++;
            if (REQ_OK !== model_ok()) begin
                errors++;
                $display("FAIL rand_ok round=%0d req_ok=%b expected %b", r, REQ_OK, model_ok());
            end
            checks++;
            if (REQ_DOUT !== model_dout()) begin
                errors++;
                $display("FAIL rand_dout round=%0d dout=%h expected %h", r, REQ_DOUT, model_dout());
            end
            run_arb(4, 0);
            @(negedge CLK96);
            checks++;
            if (ROM_CS !== 1'b0) begin
                errors++;
                $display("FAIL rand_drained round=%0d rom_cs=%b expected 0", r, ROM_CS);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single_read();
        test_cache_hit();
        test_contention();
        test_abandon();
        test_stale_ok();
        test_reset_mid_wait();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

endmodule

`default_nettype wire
